// File: rtl/bin2bcd_seq_pkg.sv
// Shared constants for the sequential binary-to-BCD converter.
// Holds the default geometry, the digit codes driven to the seven-segment
// decoders, the FSM state encoding and an elaboration-time helper that
// works out the largest value a given number of decimal digits can show.
package bin2bcd_seq_pkg;

  localparam int unsigned DEF_BIN_W  = 14;
  localparam int unsigned DEF_DIGITS = 4;

  // Digit codes understood by the seven-segment digit decoders
  localparam logic [3:0] BCD_0     = 4'h0;
  localparam logic [3:0] BCD_1     = 4'h1;
  localparam logic [3:0] BCD_2     = 4'h2;
  localparam logic [3:0] BCD_3     = 4'h3;
  localparam logic [3:0] BCD_4     = 4'h4;
  localparam logic [3:0] BCD_5     = 4'h5;
  localparam logic [3:0] BCD_6     = 4'h6;
  localparam logic [3:0] BCD_7     = 4'h7;
  localparam logic [3:0] BCD_8     = 4'h8;
  localparam logic [3:0] BCD_9     = 4'h9;
  localparam logic [3:0] BCD_A     = 4'hA;
  localparam logic [3:0] BCD_B     = 4'hB;
  localparam logic [3:0] BCD_C     = 4'hC;
  localparam logic [3:0] BCD_D     = 4'hD;
  localparam logic [3:0] BCD_E     = 4'hE;
  localparam logic [3:0] BCD_BLANK = 4'hF;

  typedef enum logic [1:0] {
    BIN2BCD_IDLE   = 2'd0,
    BIN2BCD_SHIFT  = 2'd1,
    BIN2BCD_FINISH = 2'd2
  } state_t;

  // 10^digits - 1, evaluated at elaboration
  function automatic int unsigned max_bcd_val(input int unsigned digits);
    int unsigned v;
    v = 1;
    for (int unsigned i = 0; i < digits; i++) begin
      v = v * 10;
    end
    return v - 1;
  endfunction

endpackage

// File: rtl/bin2bcd_seq_if.sv
// Request/result bundle between a datapath client and bin2bcd_seq.
// master: drives start, bin, blank_lz; observes busy, done, bcd, overflow.
// slave : the converter side of the same signals.
interface bin2bcd_seq_if
  import bin2bcd_seq_pkg::*;
#(
  parameter int unsigned BIN_W  = DEF_BIN_W,
  parameter int unsigned DIGITS = DEF_DIGITS
);

  logic                  start;
  logic [BIN_W-1:0]      bin;
  logic                  blank_lz;
  logic                  busy;
  logic                  done;
  logic [4*DIGITS-1:0]   bcd;
  logic                  overflow;

  modport master (
    output start, bin, blank_lz,
    input  busy, done, bcd, overflow
  );

  modport slave (
    input  start, bin, blank_lz,
    output busy, done, bcd, overflow
  );

endinterface

// File: rtl/bin2bcd_seq_bcd_dabble_step.sv
// One digit of the double-dabble correction: a nibble of 5 or more gets +3
// so that the following left shift carries correctly into the next digit.
// Ports: digit (scratch nibble in), adj_c (corrected nibble, combinational).
module bcd_dabble_step (
  input  logic [3:0] digit,
  output logic [3:0] adj_c
);

  always_comb begin
    adj_c = (digit >= 4'd5) ? digit + 4'd3 : digit;
  end

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter, one input bit per clock (double dabble).
// Ports: clk, rst_n (async, active low), bus (slave side of bin2bcd_seq_if):
//   start/bin/blank_lz request a conversion; busy, done pulse, bcd digit codes
//   (digit 0 in [3:0]) and overflow report the result.
module bin2bcd_seq
  import bin2bcd_seq_pkg::*;
#(
  parameter int unsigned BIN_W  = DEF_BIN_W,
  parameter int unsigned DIGITS = DEF_DIGITS
) (
  input  logic          clk,
  input  logic          rst_n,
  bin2bcd_seq_if.slave  bus
);

  localparam int unsigned BCD_W   = 4 * DIGITS;
  localparam int unsigned SH_W    = BCD_W + BIN_W;
  localparam int unsigned CNT_W   = $clog2(BIN_W + 1);
  localparam int unsigned MAX_VAL = max_bcd_val(DIGITS);

  state_t             state_q, state_d;
  logic [BIN_W-1:0]   bin_q, bin_d;
  logic [BCD_W-1:0]   scr_q, scr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               blank_q, blank_d;
  logic               ovf_flag_q, ovf_flag_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               ovf_q, ovf_d;
  logic [BCD_W-1:0]   bcd_q, bcd_d;

  logic [BCD_W-1:0]   adj_c;
  logic [SH_W-1:0]    sh_c;
  logic [BCD_W-1:0]   final_c;
  logic               lead;

  // Add-3 correction on every scratch digit ahead of the shift
  for (genvar g = 0; g < int'(DIGITS); g++) begin : g_step
    bcd_dabble_step u_step (
      .digit (scr_q[4*g +: 4]),
      .adj_c (adj_c[4*g +: 4])
    );
  end

  // Top bit of the scratch falls off here; overflow is caught up front
  assign sh_c = {adj_c, bin_q} << 1;

  // Leading-zero blanking scans from the top digit down; digit 0 always shows
  always_comb begin
    final_c = scr_q;
    lead    = blank_q;
    for (int i = int'(DIGITS) - 1; i >= 1; i--) begin
      if (lead && (scr_q[4*i +: 4] == BCD_0)) begin
        final_c[4*i +: 4] = BCD_BLANK;
      end else begin
        lead = 1'b0;
      end
    end
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= BIN2BCD_IDLE;
      bin_q      <= '0;
      scr_q      <= '0;
      cnt_q      <= '0;
      blank_q    <= 1'b0;
      ovf_flag_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      ovf_q      <= 1'b0;
      bcd_q      <= {DIGITS{BCD_BLANK}};
    end else begin
      state_q    <= state_d;
      bin_q      <= bin_d;
      scr_q      <= scr_d;
      cnt_q      <= cnt_d;
      blank_q    <= blank_d;
      ovf_flag_q <= ovf_flag_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      ovf_q      <= ovf_d;
      bcd_q      <= bcd_d;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d    = state_q;
    bin_d      = bin_q;
    scr_d      = scr_q;
    cnt_d      = cnt_q;
    blank_d    = blank_q;
    ovf_flag_d = ovf_flag_q;
    done_d     = 1'b0;
    ovf_d      = ovf_q;
    bcd_d      = bcd_q;

    case (state_q)
      BIN2BCD_IDLE: begin
        if (bus.start) begin
          bin_d      = bus.bin;
          blank_d    = bus.blank_lz;
          scr_d      = '0;
          cnt_d      = CNT_W'(BIN_W);
          ovf_flag_d = (32'(bus.bin) > MAX_VAL);
          state_d    = BIN2BCD_SHIFT;
        end
      end
      BIN2BCD_SHIFT: begin
        scr_d = sh_c[SH_W-1:BIN_W];
        bin_d = sh_c[BIN_W-1:0];
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = BIN2BCD_FINISH;
        end
      end
      BIN2BCD_FINISH: begin
        done_d  = 1'b1;
        state_d = BIN2BCD_IDLE;
        if (ovf_flag_q) begin
          bcd_d = {DIGITS{BCD_BLANK}};
          ovf_d = 1'b1;
        end else begin
          bcd_d = final_c;
          ovf_d = 1'b0;
        end
      end
      default: begin
        state_d = BIN2BCD_IDLE;
      end
    endcase

    // Busy stays up through the done cycle unless a new conversion follows
    busy_d = (state_d != BIN2BCD_IDLE) || done_d;
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.bcd      = bcd_q;
  assign bus.overflow = ovf_q;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Scoreboard bench for bin2bcd_seq: a timing/arithmetic model pushes the
// expected result at each accepted start; a monitor pops on every done.
module tb_bin2bcd_seq;

  localparam int BIN_W   = 14;
  localparam int DIGITS  = 4;
  localparam int MAX_VAL = 9999;
  localparam int LAT     = BIN_W + 1;   // edges from acceptance to done visible
  localparam int PERIOD  = BIN_W + 2;

  typedef struct {
    logic [15:0] bcd;
    logic        ovf;
    int          cyc;
    int          val;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  bin2bcd_seq_if #(.BIN_W(BIN_W), .DIGITS(DIGITS)) bus ();

  bin2bcd_seq #(.BIN_W(BIN_W), .DIGITS(DIGITS)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  exp_t        exp_q[$];
  int          n_cmp  = 0;
  int          n_fail = 0;
  int          cyc    = 0;
  int          acc_cyc = -1000;
  logic [15:0] last_bcd = 16'hFFFF;
  logic        last_ovf = 1'b0;

  function automatic void chk(input string name, input logic [31:0] act,
                              input logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, want, $time);
    end
  endfunction

  // Reference: decimal digits by division, then overflow / blanking rules
  function automatic logic [15:0] ref_bcd(input int v, input bit bl);
    int          d[4];
    logic [15:0] r;
    int          p;
    if (v > MAX_VAL) return 16'hFFFF;
    p = 1;
    for (int i = 0; i < 4; i++) begin
      d[i] = (v / p) % 10;
      p = p * 10;
    end
    if (bl) begin
      for (int i = 3; i >= 1; i--) begin
        if (d[i] != 0) break;
        d[i] = 15;
      end
    end
    r = '0;
    for (int i = 0; i < 4; i++) r[4*i +: 4] = 4'(d[i]);
    return r;
  endfunction

  // Acceptance model: start is taken when no conversion is within its window
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_q.delete();
      cyc = 0;
      acc_cyc = -1000;
    end else begin
      exp_t e;
      cyc = cyc + 1;
      if (bus.start && (cyc >= acc_cyc + PERIOD)) begin
        acc_cyc = cyc;
        e.val = int'(bus.bin);
        e.bcd = ref_bcd(e.val, bus.blank_lz);
        e.ovf = (e.val > MAX_VAL);
        e.cyc = cyc + LAT;
        exp_q.push_back(e);
      end
    end
  end

  // Monitor: done pops and checks; otherwise outputs must hold
  always @(negedge clk) begin
    if (!rst_n) begin
      last_bcd = 16'hFFFF;
      last_ovf = 1'b0;
    end else if (bus.done) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_done", 32'(bus.done), 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk($sformatf("bcd(bin=%0d)", e.val), 32'(bus.bcd), 32'(e.bcd));
        chk($sformatf("overflow(bin=%0d)", e.val), 32'(bus.overflow), 32'(e.ovf));
        chk($sformatf("done_cycle(bin=%0d)", e.val), 32'(cyc), 32'(e.cyc));
        chk("busy_in_done", 32'(bus.busy), 32'd1);
        last_bcd = e.bcd;
        last_ovf = e.ovf;
      end
    end else begin
      chk("bcd_hold", 32'(bus.bcd), 32'(last_bcd));
      chk("overflow_hold", 32'(bus.overflow), 32'(last_ovf));
    end
  end

  task automatic issue(input int v, input bit bl);
    @(negedge clk);
    bus.start    = 1'b1;
    bus.bin      = 14'(v);
    bus.blank_lz = bl;
    @(negedge clk);
    bus.start    = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) chk("done_timeout", 32'(exp_q.size()), 32'd0);
    @(negedge clk);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_bcd"},  32'(bus.bcd),      32'h0000FFFF);
    chk({tag, "_busy"}, 32'(bus.busy),     32'd0);
    chk({tag, "_done"}, 32'(bus.done),     32'd0);
    chk({tag, "_ovf"},  32'(bus.overflow), 32'd0);
  endtask

  initial begin
    int dir_v[10] = '{9999, 42, 42, 0, 10000, 1234, 16383, 9, 100, 1000};
    bit dir_b[10] = '{0,    1,  0,  1, 0,     0,    1,     1, 1,   1};

    bus.start = 1'b0; bus.bin = '0; bus.blank_lz = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk_reset_vals("reset");

    // Directed values, including the overflow boundary and blanking cases
    for (int i = 0; i < 10; i++) begin
      issue(dir_v[i], dir_b[i]);
      wait_idle();
    end

    // Start during a conversion is ignored
    issue(111, 0);
    repeat (3) @(negedge clk);
    bus.start = 1'b1; bus.bin = 14'd222;
    @(negedge clk);
    bus.start = 1'b0;
    wait_idle();

    // Reset mid-conversion aborts with no done
    issue(555, 1);
    repeat (6) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk_reset_vals("abort");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk_reset_vals("abort_release");
    repeat (20) @(negedge clk);

    // Start held high: back-to-back conversions, bin churning every cycle
    bus.start = 1'b1;
    for (int k = 0; k < PERIOD * 5; k++) begin
      bus.bin      = 14'($urandom_range(0, 16383));
      bus.blank_lz = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    bus.start = 1'b0;
    wait_idle();

    // Randomized conversions
    for (int k = 0; k < 150; k++) begin
      int v;
      v = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 16383))
                                      : int'($urandom_range(0, 9999));
      issue(v, 1'($urandom_range(0, 1)));
      wait_idle();
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    repeat (5) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
